// File: rtl/lvt_2w2r_pkg.sv
// Shared constants for the 2-write/2-read live-value table.
// Holds default widths, register count, bank-select encoding and port counts.
// Optional conflict flag is controlled by macro LVT_CONFLICT_DETECT_EN.
package lvt_2w2r_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_REGS   = 1 << DEF_ADDR_W;
  localparam logic BANK_WP0 = 1'b0;
  localparam logic BANK_WP1 = 1'b1;
  localparam int NUM_RD     = 2;
  localparam int NUM_WR     = 2;
endpackage

// File: rtl/lvt_2w2r_if.sv
// Bundle of write/read addresses, bank data and resolved outputs of the LVT.
// master drives addresses/enables/bank data; slave is the LVT itself.
// Macro LVT_CONFLICT_DETECT_EN adds the wr_conflict output.
interface lvt_2w2r_if
  import lvt_2w2r_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] b0r0_data;
  logic [DATA_W-1:0] b1r0_data;
  logic [DATA_W-1:0] b0r1_data;
  logic [DATA_W-1:0] b1r1_data;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              sel0;
  logic              sel1;
`ifdef LVT_CONFLICT_DETECT_EN
  logic              wr_conflict;
`endif

  modport master (
    output we0, waddr0, we1, waddr1, raddr0, raddr1,
    output b0r0_data, b1r0_data, b0r1_data, b1r1_data,
    input  rdata0, rdata1, sel0, sel1
`ifdef LVT_CONFLICT_DETECT_EN
    , input wr_conflict
`endif
  );

  modport slave (
    input  we0, waddr0, we1, waddr1, raddr0, raddr1,
    input  b0r0_data, b1r0_data, b0r1_data, b1r1_data,
    output rdata0, rdata1, sel0, sel1
`ifdef LVT_CONFLICT_DETECT_EN
    , output wr_conflict
`endif
  );
endinterface

// File: rtl/lvt_2w2r_rd_sel.sv
// Per-read-port live-bank select register and output data mux.
// Select registered one cycle after the address, matching the banks' read;
// same-cycle writes to the read address are forwarded (port 1 over port 0).
module lvt_rd_sel
  import lvt_2w2r_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              tbl_bit,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] b0_data,
  input  logic [DATA_W-1:0] b1_data,
  output logic              sel,
  output logic [DATA_W-1:0] rdata
);
  logic sel_nxt;

  // Next select: a write landing on this address this cycle overrides the stored bit.
  always_comb begin
    sel_nxt = tbl_bit;
    if (we1 && (waddr1 == raddr)) begin
      sel_nxt = BANK_WP1;
    end else if (we0 && (waddr0 == raddr)) begin
      sel_nxt = BANK_WP0;
    end
  end

  // Select register, aligned with the banks' registered read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel <= BANK_WP0;
    end else begin
      sel <= sel_nxt;
    end
  end

  // Pick the live bank's output.
  always_comb begin
    rdata = (sel == BANK_WP1) ? b1_data : b0_data;
  end
endmodule

// File: rtl/lvt_2w2r.sv
// Live-value table for a 2W/2R register file built from four 1W/1R banks.
// Read select latency 1 cycle with 0-cycle write-to-read bypass; no backpressure.
// Macro LVT_CONFLICT_DETECT_EN adds a registered same-address dual-write flag.
module lvt_2w2r
  import lvt_2w2r_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic      clock,
  input  logic      reset_n,
  lvt_2w2r_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  // One bit per register: which write port last wrote it. Flops, so it can clear async.
  logic [NREG-1:0] tbl;

  // Table update; port 1 is applied last so it wins a same-address dual write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbl <= '0;
    end else begin
      if (bus.we0) tbl[bus.waddr0] <= BANK_WP0;
      if (bus.we1) tbl[bus.waddr1] <= BANK_WP1;
    end
  end

  lvt_rd_sel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd0 (
    .clock   (clock),
    .reset_n (reset_n),
    .raddr   (bus.raddr0),
    .tbl_bit (tbl[bus.raddr0]),
    .we0     (bus.we0),
    .waddr0  (bus.waddr0),
    .we1     (bus.we1),
    .waddr1  (bus.waddr1),
    .b0_data (bus.b0r0_data),
    .b1_data (bus.b1r0_data),
    .sel     (bus.sel0),
    .rdata   (bus.rdata0)
  );

  lvt_rd_sel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd1 (
    .clock   (clock),
    .reset_n (reset_n),
    .raddr   (bus.raddr1),
    .tbl_bit (tbl[bus.raddr1]),
    .we0     (bus.we0),
    .waddr0  (bus.waddr0),
    .we1     (bus.we1),
    .waddr1  (bus.waddr1),
    .b0_data (bus.b0r1_data),
    .b1_data (bus.b1r1_data),
    .sel     (bus.sel1),
    .rdata   (bus.rdata1)
  );

`ifdef LVT_CONFLICT_DETECT_EN
  // Flag a cycle in which both ports wrote the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_conflict <= 1'b0;
    end else begin
      bus.wr_conflict <= bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1);
    end
  end
`endif
endmodule

// File: tb/tb_lvt_2w2r.sv
// Randomized self-checking bench for lvt_2w2r against a last-writer model.
// Model: array of "last write port" per register, updated port 0 then port 1.
// Checks sel/rdata (and wr_conflict when LVT_CONFLICT_DETECT_EN) every cycle.
module tb_lvt_2w2r;
  import lvt_2w2r_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lvt_2w2r_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lvt_2w2r #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: last writing port of each register, plus expected outputs.
  bit last_wr [NUM_REGS];
  bit exp_sel0, exp_sel1, exp_conf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) last_wr[i] = 1'b0;
    exp_sel0 = 1'b0;
    exp_sel1 = 1'b0;
    exp_conf = 1'b0;
  endtask

  task automatic rand_banks();
    bus.b0r0_data = $urandom;
    bus.b1r0_data = $urandom;
    bus.b0r1_data = $urandom;
    bus.b1r1_data = $urandom;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_sel0"}, 32'(bus.sel0), 32'(exp_sel0));
    check_eq({tag, "_sel1"}, 32'(bus.sel1), 32'(exp_sel1));
    check_eq({tag, "_rd0"}, bus.rdata0, exp_sel0 ? bus.b1r0_data : bus.b0r0_data);
    check_eq({tag, "_rd1"}, bus.rdata1, exp_sel1 ? bus.b1r1_data : bus.b0r1_data);
`ifdef LVT_CONFLICT_DETECT_EN
    check_eq({tag, "_conf"}, 32'(bus.wr_conflict), 32'(exp_conf));
`endif
  endtask

  // Present one cycle of inputs, advance the model, clock, then check.
  // A read sees the live value after this cycle's writes (bypass behaviour).
  task automatic step(input bit w0, input int a0, input bit w1, input int a1,
                      input int r0, input int r1, input string tag);
    bus.we0    = w0;
    bus.waddr0 = AW'(a0);
    bus.we1    = w1;
    bus.waddr1 = AW'(a1);
    bus.raddr0 = AW'(r0);
    bus.raddr1 = AW'(r1);
    rand_banks();
    exp_conf = w0 && w1 && (a0 == a1);
    if (w0) last_wr[a0] = 1'b0;
    if (w1) last_wr[a1] = 1'b1;
    exp_sel0 = last_wr[r0];
    exp_sel1 = last_wr[r1];
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  // Async reset pulse with writes presented during it; they must be dropped.
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    bus.we0 = 1'b1;
    bus.we1 = 1'b1;
    bus.waddr0 = AW'($urandom);
    bus.waddr1 = AW'($urandom);
    model_clear();
    #1;
    check_all({tag, "_async"});
    @(posedge clock);
    #1;
    check_all({tag, "_held"});
    @(negedge clock);
    reset_n = 1'b1;
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;
  endtask

  initial begin
    model_clear();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.waddr0 = '0; bus.waddr1 = '0;
    bus.raddr0 = '0; bus.raddr1 = '0;
    bus.b0r0_data = 32'hAAAA0000;
    bus.b1r0_data = 32'h5555FFFF;
    bus.b0r1_data = 32'h12345678;
    bus.b1r1_data = 32'h87654321;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_sel0", 32'(bus.sel0), 32'd0);
    check_eq("rst_sel1", 32'(bus.sel1), 32'd0);
    check_eq("rst_rdata0", bus.rdata0, 32'hAAAA0000);
    check_eq("rst_rdata1", bus.rdata1, 32'h12345678);
    @(negedge clock);
    reset_n = 1'b1;

    // Port-1 write to 3, idle, then read 3
    step(0, 0, 1, 3, 0, 0, "wr3");
    step(0, 0, 0, 0, 0, 0, "idle");
    step(0, 0, 0, 0, 3, 0, "rd3");
    check_eq("tp_rd3_sel0", 32'(bus.sel0), 32'd1);
    check_eq("tp_rd3_rdata0", bus.rdata0, bus.b1r0_data);

    // Same-cycle bypass: table[5] = 1, then port-0 write to 5 read at once
    step(0, 0, 1, 5, 0, 0, "set5");
    step(1, 5, 0, 0, 0, 5, "byp5");
    check_eq("tp_byp5_sel1", 32'(bus.sel1), 32'd0);

    // Dual write to 7: port 1 wins
    step(1, 7, 1, 7, 0, 0, "dual7");
`ifdef LVT_CONFLICT_DETECT_EN
    check_eq("tp_conf_hi", 32'(bus.wr_conflict), 32'd1);
`endif
    step(0, 0, 0, 0, 7, 7, "rd7");
    check_eq("tp_rd7_sel0", 32'(bus.sel0), 32'd1);
    check_eq("tp_rd7_sel1", 32'(bus.sel1), 32'd1);
`ifdef LVT_CONFLICT_DETECT_EN
    check_eq("tp_conf_lo", 32'(bus.wr_conflict), 32'd0);
`endif

    // Different addresses in the same cycle, read next cycle
    step(1, 2, 1, 9, 0, 0, "wr2_9");
    step(0, 0, 0, 0, 2, 9, "rd2_9");
    check_eq("tp_rd2_sel0", 32'(bus.sel0), 32'd0);
    check_eq("tp_rd9_sel1", 32'(bus.sel1), 32'd1);

    // Mid-stream reset clears table[4]
    step(0, 0, 1, 4, 0, 0, "set4");
    pulse_reset("rst_mid");
    step(0, 0, 0, 0, 4, 4, "rd4");
    check_eq("tp_rd4_sel0", 32'(bus.sel0), 32'd0);

    // Random traffic, narrow address range for frequent collisions
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = (n < 200) ? 3 : NUM_REGS - 1;
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, lim),
             1'($urandom_range(0, 1)), $urandom_range(0, lim),
             $urandom_range(0, lim), $urandom_range(0, lim), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lvt_2w2r.md
Name: lvt_2w2r

Overview:
- Live-value table (LVT) for the 2-write/2-read register file (fp, sp, r0–r13).
- The register file is built from 1-write/1-read banks: one bank per (write port, read port) pair, four banks total.
- This block records which write port last wrote each register.
- It registers a bank-select per read port in step with the banks' one-cycle registered read, then muxes the two candidate bank outputs into the final read data.

Parameters:
- ADDR_W, 4, register address width (16 architectural registers).
- DATA_W, 32, register data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, write port 0.
- waddr0  in  ADDR_W  write address, port 0.
- we1  in  1  write enable, write port 1.
- waddr1  in  ADDR_W  write address, port 1.
- raddr0  in  ADDR_W  read address, port 0; the same value drives the port-0 banks.
- raddr1  in  ADDR_W  read address, port 1.
- b0r0_data  in  DATA_W  registered output of the bank written by port 0, read by port 0.
- b1r0_data  in  DATA_W  registered output of the bank written by port 1, read by port 0.
- b0r1_data  in  DATA_W  bank written by port 0, read by port 1.
- b1r1_data  in  DATA_W  bank written by port 1, read by port 1.
- rdata0  out  DATA_W  resolved read data, read port 0.
- rdata1  out  DATA_W  resolved read data, read port 1.
- sel0  out  1  registered live-bank select, read port 0 (0 = port-0 bank, 1 = port-1 bank).
- sel1  out  1  registered live-bank select, read port 1.

Behaviour:
- Reset is asynchronous and active-low, on reset_n.
  - All 2^ADDR_W table entries clear to 0.
  - sel0 and sel1 clear to 0.
  - rdata0/1 therefore follow b0r0_data/b0r1_data.
  - Writes presented while reset_n = 0 are ignored.
  - Reset may assert mid-stream; the first read after deassertion resolves to bank 0.
- Table: 2^ADDR_W x 1-bit flop array (not inferred RAM, because of the async clear).
- Writes, on the rising edge:
  - we0 sets table[waddr0] to 0.
  - we1 sets table[waddr1] to 1.
  - Different addresses: both entries update.
  - Same address, both enables high: port 1 wins (entry = 1). This is the architectural priority.
- Read select, one register stage per read port; for read port r:
  - If we1 and waddr1 == raddr_r: next sel = 1.
  - Else if we0 and waddr0 == raddr_r: next sel = 0.
  - Else: next sel = table[raddr_r], using the pre-write value.
- Forwarding matches the banks, which return same-cycle write data on an address match. Read latency is therefore exactly 1 cycle, with write-to-read bypass at 0 extra cycles.
- Output mux (combinational from the registered sel):
  - rdata0 = sel0 ? b1r0_data : b0r0_data.
  - rdata1 = sel1 ? b1r1_data : b0r1_data.
- Both read ports may read the same address; each gets the identical select.
- Reading an address never written since reset returns bank 0 content.

Optional Feature:
- Macro: LVT_CONFLICT_DETECT_EN.
- Defined: adds output wr_conflict (1 bit, reset 0).
  - Pulses high for exactly one cycle, on the edge after a cycle with we0 & we1 & (waddr0 == waddr1).
  - Consecutive conflicting cycles keep it high.
- Undefined: port and logic absent.
- Port-1-wins resolution is identical either way.

Decomposition:
- Shared include/package holds:
  - ADDR_W/DATA_W defaults.
  - Register-count constant (1 << ADDR_W).
  - Bank-select encoding constants BANK_WP0 = 0, BANK_WP1 = 1.
  - Read-port count 2 and write-port count 2.
- One natural sub-module, lvt_rd_sel, instantiated once per read port:
  - Inputs: raddr, the table read bit, both write enables and addresses, both bank data inputs.
  - Outputs: registered sel and muxed rdata.

Test Plan:
- Reset → sel0 = sel1 = 0; rdata0 = b0r0_data (drive 32'hAAAA0000 / b1r0_data = 32'h5555FFFF → expect 32'hAAAA0000).
- we1 = 1, waddr1 = 3 in cycle N; raddr0 = 3 in cycle N+2 → sel0 = 1 at N+3; rdata0 = b1r0_data.
- Same-cycle bypass: we0 = 1, waddr0 = 5, raddr1 = 5 in cycle N → sel1 = 0 at N+1, although table[5] was previously 1.
- Dual write: we0 = we1 = 1, waddr0 = waddr1 = 7 → later read of 7 gives sel = 1. With LVT_CONFLICT_DETECT_EN, wr_conflict = 1 for exactly one cycle.
- Different addresses: we0 to 2, we1 to 9 in the same cycle; next cycle raddr0 = 2, raddr1 = 9 → sel0 = 0, sel1 = 1.
- Reset mid-stream: set table[4] = 1, assert reset_n = 0 for 1 cycle, then raddr0 = 4 → sel0 = 0.
